// File: rtl/paddle_engine.sv
// -----------------------------------------------------------------------------
// paddle_engine
//
// Draws a horizontal paddle on a pixel sink and moves it left/right on frame
// ticks. After reset the whole screen is cleared, the paddle is drawn at
// START_X, and the engine waits for begin_game. While running, each accepted
// tick with exactly one of left/right set erases the paddle at its old
// position and redraws it at the new one. Pixels use a valid/ready handshake.
//
// Ports
//   clk         in   single clock
//   resetn      in   synchronous active-low reset
//   tick        in   one-cycle frame strobe (consumed in RUN)
//   begin_game  in   start request (consumed in IDLE)
//   left/right  in   move requests (consumed in RUN with tick)
//   pix_ready   in   sink accepts the presented pixel
//   pix_valid   out  pixel presented
//   x_out       out  pixel column
//   y_out       out  pixel row
//   colour_out  out  pixel colour
//   paddle_x    out  current paddle left edge
//   busy        out  high while pixels are being emitted
//   move_done   out  one-cycle pulse after a move has been drawn
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CLEAR     | emit every screen pixel with colour 0
// DRAW_INIT | draw the paddle at its reset position
// IDLE      | wait for begin_game
// RUN       | wait for a tick with a single move request
// ERASE     | paint the paddle rectangle at the old position with colour 0
// DRAW      | paint the paddle rectangle at the new position with COLOUR
// -----------------------------------------------------------------------------
module paddle_engine #(
    parameter int         SCREEN_W = 160,
    parameter int         SCREEN_H = 120,
    parameter int         PADDLE_W = 16,
    parameter int         PADDLE_H = 2,
    parameter int         STEP     = 2,
    parameter int         START_X  = 72,
    parameter int         PADDLE_Y = 110,
    parameter logic [2:0] COLOUR   = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       begin_game,
    input  logic       left,
    input  logic       right,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] colour_out,
    output logic [7:0] paddle_x,
    output logic       busy,
    output logic       move_done
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_DRAW_INIT,
        S_IDLE,
        S_RUN,
        S_ERASE,
        S_DRAW
    } state_t;

    localparam logic [7:0] MAX_X       = 8'(SCREEN_W - PADDLE_W);
    localparam logic [8:0] STEP_W      = 9'(STEP);
    localparam logic [7:0] CLR_X_LAST  = 8'(SCREEN_W - 1);
    localparam logic [7:0] CLR_Y_LAST  = 8'(SCREEN_H - 1);
    localparam logic [7:0] RECT_X_LAST = 8'(PADDLE_W - 1);
    localparam logic [7:0] RECT_Y_LAST = 8'(PADDLE_H - 1);
    localparam logic [7:0] TOP_Y       = 8'(PADDLE_Y);
    localparam logic [7:0] RESET_X     = 8'(START_X);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt_x;
    logic [7:0] cnt_y;
    logic [7:0] tgt_x;

    logic       emitting;
    logic       xfer;
    logic       row_last;
    logic       scan_last;
    logic [8:0] sum_right;
    logic [7:0] tgt_left;
    logic [7:0] tgt_right;
    logic [7:0] target;
    logic       move_go;

    // Scan bookkeeping shared by the full-screen clear and the paddle rectangle.
    always_comb begin
        emitting = (state == S_CLEAR) || (state == S_DRAW_INIT) ||
                   (state == S_ERASE) || (state == S_DRAW);
        xfer     = emitting && pix_ready;
        if (state == S_CLEAR) begin
            row_last  = (cnt_x == CLR_X_LAST);
            scan_last = row_last && (cnt_y == CLR_Y_LAST);
        end else begin
            row_last  = (cnt_x == RECT_X_LAST);
            scan_last = row_last && (cnt_y == RECT_Y_LAST);
        end
    end

    // Clamped targets: compare before subtracting and add in 9 bits so no
    // legal paddle_x can underflow or wrap.
    always_comb begin
        sum_right = {1'b0, paddle_x} + STEP_W;
        tgt_right = (sum_right > {1'b0, MAX_X}) ? MAX_X : sum_right[7:0];
        tgt_left  = ({1'b0, paddle_x} < STEP_W) ? 8'd0 : (paddle_x - STEP_W[7:0]);
        target    = left ? tgt_left : tgt_right;
        move_go   = (state == S_RUN) && tick && (left ^ right) && (target != paddle_x);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR:     if (xfer && scan_last) state_nx = S_DRAW_INIT;
            S_DRAW_INIT: if (xfer && scan_last) state_nx = S_IDLE;
            S_IDLE:      if (begin_game)        state_nx = S_RUN;
            S_RUN:       if (move_go)           state_nx = S_ERASE;
            S_ERASE:     if (xfer && scan_last) state_nx = S_DRAW;
            S_DRAW:      if (xfer && scan_last) state_nx = S_RUN;
            default:                            state_nx = S_CLEAR;
        endcase
    end

    // Outputs depend only on registered state, so they hold during a stall.
    always_comb begin
        pix_valid  = emitting;
        busy       = emitting;
        colour_out = 3'd0;
        x_out      = paddle_x + cnt_x;
        y_out      = TOP_Y + cnt_y;
        case (state)
            S_CLEAR: begin
                x_out = cnt_x;
                y_out = cnt_y;
            end
            S_DRAW_INIT, S_DRAW: colour_out = COLOUR;
            default: ;
        endcase
    end

    // Scan counters, paddle position and move bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_x     <= 8'd0;
            cnt_y     <= 8'd0;
            paddle_x  <= RESET_X;
            tgt_x     <= RESET_X;
            move_done <= 1'b0;
        end else begin
            move_done <= (state == S_DRAW) && xfer && scan_last;
            if (xfer) begin
                if (row_last) begin
                    cnt_x <= 8'd0;
                    cnt_y <= scan_last ? 8'd0 : cnt_y + 8'd1;
                end else begin
                    cnt_x <= cnt_x + 8'd1;
                end
            end
            if (move_go) begin
                tgt_x <= target;
            end
            // The erase pass reads paddle_x until its final pixel is accepted.
            if ((state == S_ERASE) && xfer && scan_last) begin
                paddle_x <= tgt_x;
            end
        end
    end

endmodule

// File: tb/tb_paddle_engine.sv
module tb_paddle_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tick, begin_game, left, right, pix_ready;
    logic       pix_valid, busy, move_done;
    logic [7:0] x_out, y_out, paddle_x;
    logic [2:0] colour_out;

    logic       s1_tick, s1_begin, s1_left, s1_right;
    logic       s1_valid, s1_busy, s1_done;
    logic [7:0] s1_x, s1_y, s1_px;
    logic [2:0] s1_col;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    int w_busy, w_done, w_s1_busy, w_s1_done;

    logic [18:0] sb[$];

    logic       prev_stall = 1'b0;
    logic [18:0] prev_pix;

    always #5 clk = ~clk;

    paddle_engine u_dut (
        .clk(clk), .resetn(resetn), .tick(tick), .begin_game(begin_game),
        .left(left), .right(right), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .paddle_x(paddle_x), .busy(busy),
        .move_done(move_done)
    );

    paddle_engine #(.START_X(1)) u_s1 (
        .clk(clk), .resetn(resetn), .tick(s1_tick), .begin_game(s1_begin),
        .left(s1_left), .right(s1_right), .pix_ready(1'b1),
        .pix_valid(s1_valid), .x_out(s1_x), .y_out(s1_y),
        .colour_out(s1_col), .paddle_x(s1_px), .busy(s1_busy),
        .move_done(s1_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rect(input int x0, input logic [2:0] col);
        for (int y = 110; y < 112; y++)
            for (int x = 0; x < 16; x++)
                sb.push_back({8'(x0 + x), 8'(y), col});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input int n);
        w_busy = 0; w_done = 0; w_s1_busy = 0; w_s1_done = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy)    w_busy++;
            if (move_done) w_done++;
            if (s1_busy) w_s1_busy++;
            if (s1_done) w_s1_done++;
        end
    endtask

    // Scoreboard consumer and stall-stability monitor for the main instance.
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, pix_valid}, 32'd1);
                check("stall_pixel", {13'd0, x_out, y_out, colour_out}, {13'd0, prev_pix});
            end
            if (pix_valid && pix_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_pixel: observed=%0h expected=none",
                           {x_out, y_out, colour_out});
                end else begin
                    check("pixel", {13'd0, x_out, y_out, colour_out}, {13'd0, sb.pop_front()});
                end
            end
        end
        prev_stall = resetn && pix_valid && !pix_ready;
        prev_pix   = {x_out, y_out, colour_out};
    end

    initial begin
        int n;
        int done_seen;
        resetn = 1'b0; pix_ready = 1'b0; tick = 1'b0; begin_game = 1'b0;
        left = 1'b0; right = 1'b0;
        s1_tick = 1'b0; s1_begin = 1'b0; s1_left = 1'b0; s1_right = 1'b0;

        // Reset, then the full clear followed by the initial paddle.
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                sb.push_back({8'(x), 8'(y), 3'd0});
        push_rect(72, 3'b111);
        cycle();
        cycle();
        @(negedge clk);
        check("rst_valid", {31'd0, pix_valid}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_xy", {16'd0, x_out, y_out}, 32'd0);
        check("rst_colour", {29'd0, colour_out}, 32'd0);
        check("rst_paddle_x", {24'd0, paddle_x}, 32'd72);
        check("rst_move_done", {31'd0, move_done}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        pix_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("init_cycles", n, 32'd19232);
        check("init_sb_empty", sb.size(), 32'd0);
        check("idle_valid", {31'd0, pix_valid}, 32'd0);
        check("idle_paddle_x", {24'd0, paddle_x}, 32'd72);

        // Move requests in IDLE are ignored.
        cycle();
        tick = 1'b1; right = 1'b1;
        cycle();
        tick = 1'b0; right = 1'b0;
        window(10);
        check("idle_ignore_busy", w_busy, 32'd0);
        check("idle_ignore_px", {24'd0, paddle_x}, 32'd72);

        // START_X=1 instance: left clamps to 0, then a further left does nothing.
        cycle();
        s1_begin = 1'b1;
        cycle();
        s1_begin = 1'b0; s1_tick = 1'b1; s1_left = 1'b1;
        cycle();
        s1_tick = 1'b0; s1_left = 1'b0;
        window(80);
        check("s1_move_busy", w_s1_busy, 32'd64);
        check("s1_move_done", w_s1_done, 32'd1);
        check("s1_paddle_x", {24'd0, s1_px}, 32'd0);
        cycle();
        s1_tick = 1'b1; s1_left = 1'b1;
        cycle();
        s1_tick = 1'b0; s1_left = 1'b0;
        window(20);
        check("s1_clamp_busy", w_s1_busy, 32'd0);
        check("s1_clamp_done", w_s1_done, 32'd0);
        check("s1_clamp_px", {24'd0, s1_px}, 32'd0);

        // Start the game and move right once.
        cycle();
        begin_game = 1'b1;
        cycle();
        begin_game = 1'b0;
        push_rect(72, 3'd0);
        push_rect(74, 3'b111);
        tick = 1'b1; right = 1'b1;
        cycle();
        tick = 1'b0; right = 1'b0;
        window(100);
        check("right_busy", w_busy, 32'd64);
        check("right_done", w_done, 32'd1);
        check("right_px", {24'd0, paddle_x}, 32'd74);
        check("right_sb_empty", sb.size(), 32'd0);

        // Both or neither direction with a tick: no move.
        cycle();
        tick = 1'b1; left = 1'b1; right = 1'b1;
        cycle();
        right = 1'b0; left = 1'b0;
        cycle();
        tick = 1'b0;
        window(20);
        check("both_busy", w_busy, 32'd0);
        check("both_done", w_done, 32'd0);
        check("both_px", {24'd0, paddle_x}, 32'd74);

        // Left move with a stray tick during ERASE.
        cycle();
        push_rect(74, 3'd0);
        push_rect(72, 3'b111);
        tick = 1'b1; left = 1'b1;
        cycle();
        tick = 1'b0; left = 1'b0;
        repeat (5) cycle();
        tick = 1'b1; right = 1'b1;
        cycle();
        tick = 1'b0; right = 1'b0;
        window(120);
        check("erase_tick_busy", w_busy, 32'd58);
        check("erase_tick_done", w_done, 32'd1);
        check("erase_tick_px", {24'd0, paddle_x}, 32'd72);
        check("erase_tick_sb", sb.size(), 32'd0);

        // Right move with a randomly stalling sink.
        cycle();
        push_rect(72, 3'd0);
        push_rect(74, 3'b111);
        xfer_cnt = 0;
        tick = 1'b1; right = 1'b1;
        cycle();
        tick = 1'b0; right = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (move_done) begin
                done_seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("stall_done", done_seen, 32'd1);
        check("stall_xfers", xfer_cnt, 32'd64);
        check("stall_px", {24'd0, paddle_x}, 32'd74);
        check("stall_sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
        pix_ready = 1'b1;

        // Reset in the middle of DRAW.
        cycle();
        push_rect(74, 3'd0);
        for (int x = 72; x < 80; x++) sb.push_back({8'(x), 8'd110, 3'b111});
        tick = 1'b1; left = 1'b1;
        cycle();
        tick = 1'b0; left = 1'b0;
        repeat (40) cycle();
        pix_ready = 1'b0;
        @(negedge clk);
        check("mid_draw_pixel", {13'd0, x_out, y_out, colour_out}, {13'd0, 8'd80, 8'd110, 3'b111});
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", {31'd0, pix_valid}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_xy", {16'd0, x_out, y_out}, 32'd0);
        check("mid_rst_colour", {29'd0, colour_out}, 32'd0);
        check("mid_rst_px", {24'd0, paddle_x}, 32'd72);
        check("mid_rst_done", {31'd0, move_done}, 32'd0);
        check("mid_rst_sb", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_engine.md
PADDLE_ENGINE -- requirements
Module: paddle_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter PADDLE_W, default 16, paddle width in pixels; legal range 1..SCREEN_W.
REQ-004 SHALL have parameter PADDLE_H, default 2, paddle height in pixels; legal range 1..SCREEN_H-PADDLE_Y.
REQ-005 SHALL have parameter STEP, default 2, pixels moved per accepted tick; must be at least 1.
REQ-006 SHALL have parameter START_X, default 72, paddle left edge after reset.
REQ-007 SHALL have parameter PADDLE_Y, default 110, paddle top row.
REQ-008 SHALL have parameter COLOUR, default 3'b111, paddle colour.
REQ-009 SHALL have port clk, input, 1 bit, single clock.
REQ-010 SHALL have port resetn, input, 1 bit; reset is synchronous and active-low.
REQ-011 SHALL have port tick, input, 1 bit, one-cycle frame strobe.
REQ-012 SHALL have port begin_game, input, 1 bit, start request.
REQ-013 SHALL have ports left and right, input, 1 bit each, move requests.
REQ-014 SHALL have port pix_ready, input, 1 bit, sink accepts pixel.
REQ-015 SHALL have port pix_valid, output, 1 bit, pixel presented.
REQ-016 SHALL have port x_out, output, 8 bits, pixel column.
REQ-017 SHALL have port y_out, output, 8 bits, pixel row.
REQ-018 SHALL have port colour_out, output, 3 bits, pixel colour.
REQ-019 SHALL have port paddle_x, output, 8 bits, current paddle left edge.
REQ-020 SHALL have port busy, output, 1 bit, high while the engine is emitting pixels.
REQ-021 SHALL have port move_done, output, 1 bit, one-cycle pulse when a move completes.

Function
REQ-022 SHALL implement states CLEAR, DRAW_INIT, IDLE, RUN, ERASE and DRAW.
REQ-023 SHALL assert pix_valid and busy exactly in CLEAR, DRAW_INIT, ERASE and DRAW, and deassert both in IDLE and RUN.
REQ-024 SHALL transfer a pixel only on a cycle where pix_valid and pix_ready are both 1; scan counters SHALL advance only on transfer.
REQ-025 SHALL hold x_out, y_out and colour_out stable while pix_valid=1 and pix_ready=0.
REQ-026 CLEAR SHALL emit all SCREEN_W*SCREEN_H pixels with colour 0, x varying fastest, from (0,0) to (SCREEN_W-1,SCREEN_H-1).
REQ-027 CLEAR SHALL go to DRAW_INIT on the transfer of the last pixel.
REQ-028 DRAW_INIT and DRAW SHALL emit PADDLE_W*PADDLE_H pixels with colour COLOUR, x from paddle_x to paddle_x+PADDLE_W-1, y from PADDLE_Y to PADDLE_Y+PADDLE_H-1, x fastest.
REQ-029 ERASE SHALL emit the same rectangle as DRAW at the old paddle_x, with colour 0.
REQ-030 DRAW_INIT SHALL go to IDLE after its last transfer.
REQ-031 IDLE SHALL go to RUN on the cycle after begin_game=1 is sampled.
REQ-032 RUN, on tick=1 with exactly one of left or right set, SHALL compute a target: left gives max(paddle_x-STEP, 0); right gives min(paddle_x+STEP, SCREEN_W-PADDLE_W).
REQ-033 If the target differs from paddle_x, RUN SHALL latch the target and go to ERASE.
REQ-034 If the target equals paddle_x, or left and right are both set or both clear, RUN SHALL do nothing and emit no pixels.
REQ-035 ERASE SHALL go to DRAW after its last transfer and update paddle_x to the target on that same transfer.
REQ-036 DRAW SHALL go to RUN after its last transfer and pulse move_done for exactly that cycle.
REQ-037 tick, left, right and begin_game SHALL be ignored in every state other than the state that consumes them.
REQ-038 Arithmetic SHALL clamp without underflow or wrap for every paddle_x value in 0..SCREEN_W-PADDLE_W.
REQ-039 With pix_ready held at 1: CLEAR SHALL take SCREEN_W*SCREEN_H cycles, and ERASE and DRAW SHALL each take PADDLE_W*PADDLE_H cycles.

Reset
REQ-040 resetn=0 at a clk edge SHALL load state CLEAR, scan counters 0, paddle_x=START_X and move_done=0, in any state including mid-scan.
REQ-041 The cycle after reset SHALL present pix_valid=1, busy=1, x_out=0, y_out=0 and colour_out=0.

Verification
REQ-042 Reset with pix_ready=1 -> 19200 colour-0 pixels ending at (159,119), then 32 pixels of colour 7 at x 72..87, y 110..111, then busy=0.
REQ-043 begin_game, then right=1 with one tick -> 32 colour-0 pixels at x 72..87, then 32 colour-7 pixels at x 74..89; paddle_x=74; one move_done pulse.
REQ-044 START_X=1 with left=1 and a tick -> paddle_x=0; a second left tick -> no pixels and no move_done.
REQ-045 pix_ready random at 50% during DRAW -> outputs stable across every stall; exactly 32 transfers; same coordinate sequence as with pix_ready=1.
REQ-046 left=right=1 with a tick -> no move; a tick during ERASE -> no extra move after DRAW completes.
REQ-047 resetn=0 for one cycle mid-DRAW -> next cycle is CLEAR with (0,0), colour 0, paddle_x=72.
